// File: rtl/cpu_pkg.sv
// Shared definitions for the simple_cpu instruction interface: word classes,
// field positions, hold-cycle counts and the issuer state encoding.
package cpu_pkg;

   localparam int INSTR_W    = 20;
   localparam int PROG_W     = 4;
   localparam int HOLD_STD   = 3;
   localparam int HOLD_LOAD  = 4;
   localparam int HOLD_STORE = 3;
   localparam int CNT_W      = 4;

   localparam logic [1:0] CLS_HALT  = 2'b00;
   localparam logic [1:0] CLS_STD   = 2'b01;
   localparam logic [1:0] CLS_LOAD  = 2'b10;
   localparam logic [1:0] CLS_STORE = 2'b11;

   localparam int CLS_HI  = 19;
   localparam int CLS_LO  = 18;
   localparam int DEST_HI = 17;
   localparam int DEST_LO = 16;
   localparam int X2_HI   = 15;
   localparam int X2_LO   = 14;
   localparam int X3_HI   = 13;
   localparam int X3_LO   = 12;
   localparam int OFF_HI  = 11;
   localparam int OFF_LO  = 4;
   localparam int OPC_HI  = 3;
   localparam int OPC_LO  = 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRIME,
      ST_ISSUE,
      ST_DONE
   } issuer_state_t;

   function automatic logic [1:0] instr_class(input logic [INSTR_W-1:0] word);
      return word[CLS_HI:CLS_LO];
   endfunction

endpackage

// File: rtl/prog_store.sv
// Writable program store for the instruction issuer: one synchronous write
// port and one combinational read port; contents are never reset.
module prog_store #(
   parameter int ADDR_BITS  = 4,
   parameter int DATA_WIDTH = 20
) (
   input  logic                  clk_i,
   input  logic                  wr_en_i,
   input  logic [ADDR_BITS-1:0]  wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic [ADDR_BITS-1:0]  rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_BITS];

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/instr_issuer.sv
// Program sequencer driving the simple_cpu instruction port, holding each word
// for its class's control-unit cycle count. Define ISSUER_PERF_EN for run counters.
module instr_issuer
   import cpu_pkg::*;
#(
   parameter int INSTR_WIDTH  = INSTR_W,
   parameter int PROG_BITS    = PROG_W,
   parameter int STD_CYCLES   = HOLD_STD,
   parameter int LOAD_CYCLES  = HOLD_LOAD,
   parameter int STORE_CYCLES = HOLD_STORE
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   prog_wen_i,
   input  logic [PROG_BITS-1:0]   prog_addr_i,
   input  logic [INSTR_WIDTH-1:0] prog_data_i,
   input  logic [PROG_BITS-1:0]   prog_last_i,
   input  logic                   start_i,
   output logic [INSTR_WIDTH-1:0] instruction_o,
   output logic                   issue_o,
   output logic [PROG_BITS-1:0]   pc_o,
   output logic                   busy_o,
   output logic                   done_o
`ifdef ISSUER_PERF_EN
   ,
   output logic [15:0]            run_cycles_o,
   output logic [PROG_BITS:0]     instr_count_o
`endif
);

   issuer_state_t          state_q, state_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic [PROG_BITS-1:0]   pc_q, pc_d;
   logic [PROG_BITS-1:0]   last_q, last_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   issue_q, issue_d;

   logic                   wr_en;
   logic                   start_go;
   logic [PROG_BITS-1:0]   rd_addr;
   logic [INSTR_WIDTH-1:0] rd_data;
   logic [1:0]             rd_cls;

   // The PRIME cycle or the issuing cycle itself counts as the first hold edge.
   function automatic logic [CNT_W-1:0] hold_m1(input logic [1:0] cls);
      case (cls)
         CLS_LOAD:  return CNT_W'(LOAD_CYCLES - 1);
         CLS_STORE: return CNT_W'(STORE_CYCLES - 1);
         default:   return CNT_W'(STD_CYCLES - 1);
      endcase
   endfunction

   assign wr_en    = (state_q == ST_IDLE) && prog_wen_i;
   assign start_go = (state_q == ST_IDLE) && start_i && !prog_wen_i;
   assign rd_addr  = (state_q == ST_IDLE) ? '0 : pc_q + PROG_BITS'(1);
   assign rd_cls   = instr_class(rd_data);

   prog_store #(
      .ADDR_BITS  (PROG_BITS),
      .DATA_WIDTH (INSTR_WIDTH)
   ) u_store (
      .clk_i     (clk_i),
      .wr_en_i   (wr_en),
      .wr_addr_i (prog_addr_i),
      .wr_data_i (prog_data_i),
      .rd_addr_i (rd_addr),
      .rd_data_o (rd_data)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         instr_q <= '0;
         pc_q    <= '0;
         last_q  <= '0;
         cnt_q   <= '0;
         issue_q <= 1'b0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         issue_q <= issue_d;
      end
   end

   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      issue_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            instr_d = '0;
            if (start_go) begin
               last_d = prog_last_i;
               pc_d   = '0;
               if (rd_cls == CLS_HALT) begin
                  state_d = ST_DONE;
               end else begin
                  instr_d = rd_data;
                  issue_d = 1'b1;
                  state_d = ST_PRIME;
               end
            end
         end
         ST_PRIME: begin
            cnt_d   = hold_m1(instr_class(instr_q));
            state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (pc_q == last_q || rd_cls == CLS_HALT) begin
               instr_d = '0;
               state_d = ST_DONE;
            end else begin
               pc_d    = pc_q + PROG_BITS'(1);
               instr_d = rd_data;
               issue_d = 1'b1;
               cnt_d   = hold_m1(rd_cls);
            end
         end
         ST_DONE: begin
            instr_d = '0;
            state_d = ST_IDLE;
         end
         default: begin
            instr_d = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   assign instruction_o = instr_q;
   assign issue_o       = issue_q;
   assign pc_o          = pc_q;
   assign busy_o        = (state_q == ST_PRIME) || (state_q == ST_ISSUE);
   assign done_o        = (state_q == ST_DONE);

`ifdef ISSUER_PERF_EN
   logic [15:0]        run_cycles_q;
   logic [PROG_BITS:0] instr_count_q;

   // Counters keep their final values after a run until the next accepted start.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         run_cycles_q  <= '0;
         instr_count_q <= '0;
      end else if (start_go) begin
         run_cycles_q  <= '0;
         instr_count_q <= '0;
      end else begin
         if (busy_o && run_cycles_q != 16'hFFFF) begin
            run_cycles_q <= run_cycles_q + 16'd1;
         end
         if (issue_q) begin
            instr_count_q <= instr_count_q + (PROG_BITS+1)'(1);
         end
      end
   end

   assign run_cycles_o  = run_cycles_q;
   assign instr_count_o = instr_count_q;
`endif

endmodule

// File: tb/tb_instr_issuer.sv
// Directed self-checking bench for instr_issuer: single, mixed, halting,
// full-length and disturbed runs plus asynchronous reset.
module tb_instr_issuer;

   logic        clk;
   logic        rst_n;
   logic        prog_wen;
   logic [3:0]  prog_addr;
   logic [19:0] prog_data;
   logic [3:0]  prog_last;
   logic        start;
   logic [19:0] instruction;
   logic        issue;
   logic [3:0]  pc;
   logic        busy;
   logic        done;
`ifdef ISSUER_PERF_EN
   logic [15:0] run_cycles;
   logic [4:0]  instr_count;
`endif

   int total;
   int bad;

   logic [63:0] issueMask;
   logic [63:0] doneMask;
   int          busyCnt;
   logic [3:0]  pcOr;
   logic [19:0] instrAt [64];
   logic [3:0]  pcAt [64];

   instr_issuer dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .prog_wen_i    (prog_wen),
      .prog_addr_i   (prog_addr),
      .prog_data_i   (prog_data),
      .prog_last_i   (prog_last),
      .start_i       (start),
      .instruction_o (instruction),
      .issue_o       (issue),
      .pc_o          (pc),
      .busy_o        (busy),
      .done_o        (done)
`ifdef ISSUER_PERF_EN
      ,
      .run_cycles_o  (run_cycles),
      .instr_count_o (instr_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, then return one ns after the sampling edge.
   task automatic applyStimulus(input logic wen, input logic [3:0] addr, input logic [19:0] data,
                                input logic [3:0] last, input logic st);
      prog_wen  = wen;
      prog_addr = addr;
      prog_data = data;
      prog_last = last;
      start     = st;
      tick();
      prog_wen  = 1'b0;
      start     = 1'b0;
   endtask

   // Start a run and record ncyc cycles; at pokeCyc, pulse start and a write.
   task automatic runProgram(input logic [3:0] last, input int ncyc, input int pokeCyc);
      issueMask = '0;
      doneMask  = '0;
      busyCnt   = 0;
      pcOr      = '0;
      applyStimulus(1'b0, 4'd0, 20'h0, last, 1'b1);
      for (int cyc = 1; cyc <= ncyc; cyc++) begin
         if (issue) issueMask[cyc] = 1'b1;
         if (done)  doneMask[cyc]  = 1'b1;
         if (busy)  busyCnt++;
         instrAt[cyc] = instruction;
         pcAt[cyc]    = pc;
         pcOr         = pcOr | pc;
         if (cyc == pokeCyc) begin
            start     = 1'b1;
            prog_wen  = 1'b1;
            prog_addr = 4'd0;
            prog_data = 20'hFFFFF;
            prog_last = 4'd15;
         end
         tick();
         start    = 1'b0;
         prog_wen = 1'b0;
      end
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      prog_wen  = 1'b0;
      prog_addr = '0;
      prog_data = '0;
      prog_last = '0;
      start     = 1'b0;
      tick();
      tick();
      checkOutput("rst_instr", 64'(instruction), 64'h0);
      checkOutput("rst_pc",    64'(pc),          64'h0);
      checkOutput("rst_busy",  64'(busy),        64'h0);
      checkOutput("rst_issue", 64'(issue),       64'h0);
      checkOutput("rst_done",  64'(done),        64'h0);
      rst_n = 1'b1;
      tick();

      // single std_op
      applyStimulus(1'b1, 4'd0, 20'h5B000, 4'd0, 1'b0);
      runProgram(4'd0, 8, 0);
      checkOutput("single_issue", issueMask, 64'h2);
      checkOutput("single_busy",  64'(busyCnt), 64'd4);
      checkOutput("single_done",  doneMask, 64'h20);
      checkOutput("single_hold4", 64'(instrAt[4]), 64'h5B000);
      checkOutput("single_clr5",  64'(instrAt[5]), 64'h0);

      // mixed std / load / store
      applyStimulus(1'b1, 4'd1, 20'hA0040, 4'd0, 1'b0);
      applyStimulus(1'b1, 4'd2, 20'hF0050, 4'd0, 1'b0);
      runProgram(4'd2, 14, 0);
      checkOutput("mixed_issue", issueMask, 64'h222);
      checkOutput("mixed_busy",  64'(busyCnt), 64'd11);
      checkOutput("mixed_done",  doneMask, 64'h1000);
      checkOutput("mixed_w1",    64'(instrAt[5]), 64'hA0040);
      checkOutput("mixed_w1end", 64'(instrAt[8]), 64'hA0040);
      checkOutput("mixed_pc9",   64'(pcAt[9]), 64'd2);
`ifdef ISSUER_PERF_EN
      checkOutput("perf_cycles", 64'(run_cycles), 64'd11);
      checkOutput("perf_count",  64'(instr_count), 64'd3);
      tick();
      checkOutput("perf_cycles_hold", 64'(run_cycles), 64'd11);
      checkOutput("perf_count_hold",  64'(instr_count), 64'd3);
`endif

      // reset in ISSUE at cycle 5, then rerun from preserved memory
      applyStimulus(1'b0, 4'd0, 20'h0, 4'd2, 1'b1);
      repeat (4) tick();
      checkOutput("pre_rst_busy", 64'(busy), 64'h1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midrst_instr", 64'(instruction), 64'h0);
      checkOutput("midrst_busy",  64'(busy), 64'h0);
      checkOutput("midrst_pc",    64'(pc), 64'h0);
      #2 rst_n = 1'b1;
      runProgram(4'd2, 14, 0);
      checkOutput("rerun_w0", 64'(instrAt[1]), 64'h5B000);
      checkOutput("rerun_w1", 64'(instrAt[5]), 64'hA0040);
      checkOutput("rerun_w2", 64'(instrAt[9]), 64'hF0050);

      // start / write / prog_last disturbances while busy
      runProgram(4'd0, 10, 2);
      checkOutput("busyign_issue", issueMask, 64'h2);
      checkOutput("busyign_busy",  64'(busyCnt), 64'd4);
      checkOutput("busyign_done",  doneMask, 64'h20);
      runProgram(4'd0, 8, 0);
      checkOutput("busyign_mem0", 64'(instrAt[1]), 64'h5B000);

      // write with start in IDLE: write wins, no run
      applyStimulus(1'b1, 4'd0, 20'hF0050, 4'd0, 1'b1);
      checkOutput("wenstart_busy",  64'(busy), 64'h0);
      checkOutput("wenstart_issue", 64'(issue), 64'h0);
      tick();
      checkOutput("wenstart_busy2", 64'(busy), 64'h0);
      runProgram(4'd0, 8, 0);
      checkOutput("wenstart_mem0", 64'(instrAt[1]), 64'hF0050);
      checkOutput("store_busy",    64'(busyCnt), 64'd4);

      // halt word inside the run
      applyStimulus(1'b1, 4'd0, 20'hA0040, 4'd0, 1'b0);
      applyStimulus(1'b1, 4'd1, 20'h00000, 4'd0, 1'b0);
      applyStimulus(1'b1, 4'd2, 20'h5B000, 4'd0, 1'b0);
      runProgram(4'd2, 10, 0);
      checkOutput("halt_issue", issueMask, 64'h2);
      checkOutput("halt_busy",  64'(busyCnt), 64'd5);
      checkOutput("halt_done",  doneMask, 64'h40);
      checkOutput("halt_pc",    64'(pcOr), 64'h0);

      // halt word at address 0
      applyStimulus(1'b1, 4'd0, 20'h00000, 4'd0, 1'b0);
      runProgram(4'd2, 5, 0);
      checkOutput("halt0_issue", issueMask, 64'h0);
      checkOutput("halt0_busy",  64'(busyCnt), 64'd0);
      checkOutput("halt0_done",  doneMask, 64'h2);

      // full store, last = 15, no wrap
      for (int a = 0; a < 16; a++) begin
         applyStimulus(1'b1, 4'(a), 20'h5B000, 4'd0, 1'b0);
      end
      runProgram(4'd15, 60, 0);
      checkOutput("full_busy",   64'(busyCnt), 64'd49);
      checkOutput("full_issues", 64'($countones(issueMask)), 64'd16);
      checkOutput("full_done",   doneMask, 64'h1 << 50);
      checkOutput("full_pc49",   64'(pcAt[49]), 64'd15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
